// File: rtl/p2p_down_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : p2p_down_arbiter
// Brief    : Packet-granular round-robin arbiter for the p2p forward down
//            channel, with a per-packet beat-count vs head-length check.
// Revision : 1.0 - initial release
// =============================================================================
module p2p_down_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int C_DATA_WIDTH    = 256,
    parameter int DOWN_HEAD_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 iv_src_valid,
    input  logic [NUM_SRC-1:0]                 iv_src_last,
    input  logic [NUM_SRC*C_DATA_WIDTH-1:0]    iv_src_data,
    input  logic [NUM_SRC*DOWN_HEAD_WIDTH-1:0] iv_src_head,
    output logic [NUM_SRC-1:0]                 ov_src_ready,
    output logic                               p2p_rx_valid,
    output logic                               p2p_rx_last,
    output logic [C_DATA_WIDTH-1:0]            p2p_rx_data,
    output logic [DOWN_HEAD_WIDTH-1:0]         p2p_rx_head,
    input  logic                               p2p_rx_ready,
    output logic [NUM_SRC-1:0]                 ov_grant,
    output logic                               o_len_err,
    output logic [2:0]                         ov_err_src
);

    localparam int          BPB     = C_DATA_WIDTH / 8;
    localparam int          IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           r_rr_ptr;
    logic [IDX_W-1:0]           w_pick_idx;
    logic                       w_pick_found;
    logic                       w_sel_valid;
    logic                       w_sel_last;
    logic [C_DATA_WIDTH-1:0]    w_sel_data;
    logic [DOWN_HEAD_WIDTH-1:0] w_sel_head;
    logic                       w_busy;
    logic                       w_accept;
    logic                       w_accept_last;
    logic                       r_first;
    logic [11:0]                r_beat_cnt;
    logic [11:0]                r_exp_beats;
    logic [11:0]                w_cur_cnt;
    logic [11:0]                w_cur_exp;
    logic [11:0]                w_head_beats;
    logic [16:0]                w_len_ceil;
    logic                       r_len_err;
    logic [2:0]                 r_err_src;

    // First requester strictly after the previous winner, wrapping around.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_pick_found && iv_src_valid[i] &&
                    ((int'(r_rr_ptr) + k) % NUM_SRC) == i) begin
                    w_pick_found = 1'b1;
                    w_pick_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_head  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_valid = iv_src_valid[i];
                w_sel_last  = iv_src_last[i];
                w_sel_data  = iv_src_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                w_sel_head  = iv_src_head[i*DOWN_HEAD_WIDTH +: DOWN_HEAD_WIDTH];
            end
        end
    end

    assign w_busy        = (r_state == S_BUSY);
    assign w_accept      = w_busy && w_sel_valid && p2p_rx_ready;
    assign w_accept_last = w_accept && w_sel_last;

    // Expected beats from the head; a zero length still occupies one beat.
    assign w_len_ceil   = ({1'b0, w_sel_head[15:0]} + 17'(BPB - 1)) / 17'(BPB);
    assign w_head_beats = (w_len_ceil == 17'd0)  ? 12'd1   :
                          (|w_len_ceil[16:12])   ? CNT_MAX : w_len_ceil[11:0];

    assign w_cur_exp = r_first ? w_head_beats : r_exp_beats;
    assign w_cur_cnt = r_first                 ? 12'd1   :
                       (r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + 12'd1;

    always_comb begin
        w_state_nxt  = r_state;
        p2p_rx_valid = 1'b0;
        p2p_rx_last  = 1'b0;
        p2p_rx_data  = '0;
        p2p_rx_head  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                p2p_rx_valid = w_sel_valid;
                p2p_rx_last  = w_sel_last;
                p2p_rx_data  = w_sel_data;
                p2p_rx_head  = w_sel_head;
                if (w_accept_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign ov_grant[gi]     = w_busy && (r_idx == IDX_W'(gi));
            assign ov_src_ready[gi] = ov_grant[gi] && p2p_rx_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_rr_ptr    <= IDX_W'(NUM_SRC - 1);
            r_first     <= 1'b0;
            r_beat_cnt  <= '0;
            r_exp_beats <= '0;
            r_len_err   <= 1'b0;
            r_err_src   <= '0;
        end else begin
            r_len_err <= 1'b0;
            if (!w_busy && w_pick_found) begin
                r_idx   <= w_pick_idx;
                r_first <= 1'b1;
            end
            if (w_accept) begin
                r_first     <= 1'b0;
                r_beat_cnt  <= w_cur_cnt;
                r_exp_beats <= w_cur_exp;
                if (w_accept_last) begin
                    r_rr_ptr <= r_idx;
                    if (w_cur_cnt != w_cur_exp) begin
                        r_len_err <= 1'b1;
                        r_err_src <= 3'(r_idx);
                    end
                end
            end
        end
    end

    assign o_len_err  = r_len_err;
    assign ov_err_src = r_err_src;

endmodule
`default_nettype wire
